// File: rtl/as_arb_pkg.sv
// Shared types and widths for the FIFO write-side arbiter and its round-robin picker.
// Reused by the read-side scheduler; keep it free of per-instance parameters.
package as_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int BYTE_CNT_W = 12;
    localparam int IDLE_CNT_W = 8;

    // Requester index width; a 2-requester arbiter still needs one bit.
    function automatic int req_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/as_fifo_wr_arbiter_if.sv
// Requester byte streams plus the FIFO write port, bundled for the arbiter.
// Handshake: a byte moves on a clock edge where req_valid[i] && req_ready[i]; valid must not wait for ready.
interface as_fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           fifo_wr_data;
    logic                 fifo_wr_en;
    logic                 fifo_afull;

    // master: the requesters and the FIFO; slave: the arbiter.
    modport master (
        output req_valid, req_data, req_last, fifo_afull,
        input  req_ready, fifo_wr_data, fifo_wr_en
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_afull,
        output req_ready, fifo_wr_data, fifo_wr_en
    );

endinterface

// File: rtl/as_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_i, wrapping.
// Returns a one-hot pick and a valid flag; no state, so it can serve other schedulers.
module as_rr_pick
    import as_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = req_idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  pick_o,
    output logic          valid_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        // Offset 1..N visits last_i itself last, so a lone requester can win again.
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_i) + k) % N);
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid_o = found;

endmodule

// File: rtl/as_fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter in front of the bridge FIFO write port.
// Optional mid-packet idle timeout: define AS_FIFO_WR_ARB_TIMEOUT_EN.
module as_fifo_wr_arbiter
    import as_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_PKT = 256,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    as_fifo_wr_arbiter_if.slave  bus,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 pkt_trunc,
    output arb_state_e           dbg_state_o
);

    localparam int IDX_W = req_idx_w(NUM_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_PKT < 2 || MAX_PKT > 4096 ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("as_fifo_wr_arbiter: parameter out of range");
    end

    arb_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    idx_t                    owner_q, owner_d;
    idx_t                    last_q, last_d;
    logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    trunc_q, trunc_d;
`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
    logic [IDLE_CNT_W-1:0]   idle_q, idle_d;
    logic [IDLE_CNT_W-1:0]   idle_inc;
`endif

    logic [NUM_REQ-1:0]      pick;
    logic                    pick_valid;
    idx_t                    pick_idx;
    logic                    owner_valid;
    logic                    owner_last;
    logic [7:0]              owner_data;
    logic                    xfer;
    logic                    rel;
    logic [BYTE_CNT_W:0]     cnt_next;
    logic                    max_hit;

    as_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = idx_t'(i);
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == idx_t'(i)) begin
                owner_data = bus.req_data[i*8 +: 8];
            end
        end
    end

    assign owner_valid = bus.req_valid[owner_q];
    assign owner_last  = bus.req_last[owner_q];
    assign xfer        = (state_q == OWN) && owner_valid && !bus.fifo_afull;

    // One extra bit so MAX_PKT = 4096 is reachable from a 12-bit counter.
    assign cnt_next = {1'b0, cnt_q} + {{BYTE_CNT_W{1'b0}}, 1'b1};
    assign max_hit  = (cnt_next == (BYTE_CNT_W+1)'(MAX_PKT));

`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
    assign idle_inc = idle_q + {{(IDLE_CNT_W-1){1'b0}}, 1'b1};
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        trunc_d = 1'b0;
        rel     = 1'b0;
`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
        idle_d  = idle_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
                idle_d = '0;
`endif
                if (pick_valid) begin
                    state_d = OWN;
                    grant_d = pick;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (xfer) begin
                    cnt_d = cnt_next[BYTE_CNT_W-1:0];
`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
                    idle_d = '0;
`endif
                    // A last byte landing on MAX_PKT is a clean end, not a truncation.
                    if (owner_last) begin
                        rel = 1'b1;
                    end else if (max_hit) begin
                        rel     = 1'b1;
                        trunc_d = 1'b1;
                    end
                end
`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
                else if (bus.fifo_afull) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_inc;
                    if (idle_inc == IDLE_CNT_W'(TIMEOUT)) begin
                        rel     = 1'b1;
                        trunc_d = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (rel) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
            last_d  = owner_q;
`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
            idle_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= idx_t'(NUM_REQ - 1);
            cnt_q   <= '0;
            trunc_q <= 1'b0;
`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

    // Only the owner ever sees ready, so writes from different requesters cannot mix.
    assign bus.req_ready    = ((state_q == OWN) && !bus.fifo_afull) ? grant_q : '0;
    assign bus.fifo_wr_en   = xfer;
    assign bus.fifo_wr_data = owner_data;

    assign grant       = grant_q;
    assign busy        = (state_q == OWN);
    assign pkt_trunc   = trunc_q;
    assign dbg_state_o = state_q;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));

endmodule

// File: tb/tb_as_fifo_wr_arbiter.sv
// Directed bench for as_fifo_wr_arbiter (NUM_REQ=4, MAX_PKT=4, TIMEOUT=10) with a cycle-level model.
// Build with or without AS_FIFO_WR_ARB_TIMEOUT_EN; the model and the timeout test follow the macro.
module tb_as_fifo_wr_arbiter;
    import as_arb_pkg::*;

    localparam int N    = 4;
    localparam int MAXP = 4;
    localparam int TMO  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [N-1:0] grant;
    logic       busy;
    logic       pkt_trunc;
    arb_state_e dbg_state;

    as_fifo_wr_arbiter_if #(.NUM_REQ(N)) bus ();

    as_fifo_wr_arbiter #(
        .NUM_REQ (N),
        .MAX_PKT (MAXP),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .grant       (grant),
        .busy        (busy),
        .pkt_trunc   (pkt_trunc),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] src_q [N][$];
    logic [7:0] exp_q [$];
    int         gseq [$];
    int         gap_q [$];

    logic [N-1:0] en = '0;
    logic [N-1:0] hs_mask = '0;
    logic         afull_drv = 1'b0;
    logic         reset_drv = 1'b1;
    int           n_wr = 0;
    int           n_trunc = 0;

    // Model: owner (-1 when nobody holds the FIFO), last owner, bytes in grant, idle cycles.
    int   m_owner = -1;
    int   m_last  = N - 1;
    int   m_bytes = 0;
    int   m_idle  = 0;
    logic m_trunc = 1'b0;

    logic [N-1:0] prev_grant = '0;
    logic         prev_busy = 1'b0;
    logic         gap_on = 1'b0;
    int           gap_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_pkt(input int i, input int n, input logic [7:0] base, input bit with_last);
        for (int k = 0; k < n; k++) begin
            src_q[i].push_back({(with_last && k == n - 1), 8'(base + k)});
        end
    endtask

    task automatic exp_bytes(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(8'(base + k));
    endtask

    // One clock: retire bytes handshaken last edge, drive new inputs, let outputs settle.
    task automatic cycle();
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [N*8-1:0] d;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (hs_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                v[i]         = 1'b1;
                l[i]         = src_q[i][0][8];
                d[i*8 +: 8]  = src_q[i][0][7:0];
            end
        end
        bus.req_valid  = v;
        bus.req_last   = l;
        bus.req_data   = d;
        bus.fifo_afull = afull_drv;
        reset          = reset_drv;
        #2;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int c = 0;
        while (!(all_empty() && !busy) && c < bound) begin
            cycle();
            c++;
        end
        if (c >= bound) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: not idle after %0d cycles", name, bound);
        end
    endtask

    task automatic wait_wr(input string name, input int target, input int bound);
        int c = 0;
        while (n_wr < target && c < bound) begin
            cycle();
            c++;
        end
        if (n_wr < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: %0d writes seen, %0d required", name, n_wr, target);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model, then advance the model.
    always @(negedge clk) begin
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        logic         e_wr;
        int           gi;
        #1;
        e_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        e_ready = (m_owner >= 0 && !bus.fifo_afull) ? e_grant : '0;
        e_wr    = (m_owner >= 0) && bus.req_valid[m_owner] && !bus.fifo_afull;

        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("state", 32'(dbg_state), 32'(m_owner >= 0));
        chk("pkt_trunc", 32'(pkt_trunc), 32'(m_trunc));
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e_wr));
        if (e_wr) chk("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(bus.req_data[m_owner*8 +: 8]));

        if (bus.fifo_wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_extra: unexpected byte %0h", bus.fifo_wr_data);
            end else begin
                chk("sb_data", 32'(bus.fifo_wr_data), 32'(exp_q.pop_front()));
            end
        end
        if (pkt_trunc) n_trunc++;

        if (grant != '0 && prev_grant == '0) begin
            gi = -1;
            for (int i = 0; i < N; i++) if (grant[i]) gi = i;
            gseq.push_back(gi);
        end
        prev_grant = grant;

        if (reset) begin
            gap_on = 1'b0;
        end else if (!busy) begin
            if (prev_busy) begin
                gap_on  = 1'b1;
                gap_len = 0;
            end
            if (gap_on) gap_len++;
        end else if (gap_on) begin
            gap_q.push_back(gap_len);
            gap_on = 1'b0;
        end
        prev_busy = busy;

        hs_mask = bus.req_valid & bus.req_ready;

        if (reset) begin
            m_owner = -1;
            m_last  = N - 1;
            m_bytes = 0;
            m_idle  = 0;
            m_trunc = 1'b0;
        end else if (m_owner < 0) begin
            m_trunc = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (bus.req_valid[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_bytes = 0;
                    m_idle  = 0;
                    break;
                end
            end
        end else begin
            m_trunc = 1'b0;
            if (e_wr) begin
                m_bytes++;
                m_idle = 0;
                if (bus.req_last[m_owner] || m_bytes == MAXP) begin
                    m_trunc = !bus.req_last[m_owner];
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
            else if (bus.fifo_afull) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_trunc = 1'b1;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
`endif
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_seq [5];
        int t0;
        int base;

        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_last   = '0;
        bus.req_data   = '0;
        bus.fifo_afull = 1'b0;

        // Reset values.
        cycle();
        cycle();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_trunc", 32'(pkt_trunc), 32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);

        // Requesters 0 and 2: grant after one cycle, then 0's packet, then 2's.
        reset_drv = 1'b0;
        push_pkt(0, 3, 8'h00, 1'b1);
        push_pkt(2, 2, 8'h20, 1'b1);
        exp_bytes(8'h00, 3);
        exp_bytes(8'h20, 2);
        en = 4'b0101;
        cycle();
        chk("t1_no_grant_yet", 32'(grant), 32'h0);
        chk("t1_no_write_yet", 32'(bus.fifo_wr_en), 32'h0);
        cycle();
        chk("t1_grant_req0", 32'(grant), 32'b0001);
        wait_idle("t1_idle", 40);
        chk("t1_gseq_len", 32'(gseq.size()), 32'd2);
        chk("t1_gseq_0", 32'(gseq[0]), 32'd0);
        chk("t1_gseq_1", 32'(gseq[1]), 32'd2);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // All four with 2-byte packets: 0,1,2,3,0 and one idle cycle between packets.
        reset_drv = 1'b1;
        cycle();
        reset_drv = 1'b0;
        cycle();
        gseq.delete();
        gap_q.delete();
        for (int i = 0; i < N; i++) begin
            push_pkt(i, 2, 8'(i * 16 + 8), 1'b1);
            exp_bytes(8'(i * 16 + 8), 2);
        end
        push_pkt(0, 2, 8'h0C, 1'b1);
        exp_bytes(8'h0C, 2);
        en = 4'b1111;
        wait_idle("t2_idle", 80);
        e_seq = '{0, 1, 2, 3, 0};
        chk("t2_gseq_len", 32'(gseq.size()), 32'd5);
        for (int i = 0; i < 5 && i < gseq.size(); i++) chk("t2_gseq", 32'(gseq[i]), 32'(e_seq[i]));
        chk("t2_gap_cnt", 32'(gap_q.size()), 32'd4);
        for (int i = 0; i < gap_q.size(); i++) chk("t2_gap_len", 32'(gap_q[i]), 32'd1);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Almost-full for 5 cycles mid-packet; last byte also lands on MAX_PKT.
        en   = 4'b0010;
        push_pkt(1, 4, 8'h50, 1'b1);
        exp_bytes(8'h50, 4);
        base = n_wr;
        t0   = n_trunc;
        wait_wr("t3_first_two", base + 2, 20);
        afull_drv = 1'b1;
        repeat (5) begin
            cycle();
            chk("t3_stall_wr_en", 32'(bus.fifo_wr_en), 32'h0);
            chk("t3_stall_ready", 32'(bus.req_ready), 32'h0);
            chk("t3_stall_grant", 32'(grant), 32'b0010);
        end
        afull_drv = 1'b0;
        wait_idle("t3_idle", 20);
        chk("t3_bytes", 32'(n_wr - base), 32'd4);
        chk("t3_no_trunc", 32'(n_trunc - t0), 32'd0);

        // Requester 1 sends 6 bytes without last: truncated after 4, requester 2 slips in.
        gseq.delete();
        t0   = n_trunc;
        base = n_wr;
        en   = 4'b0010;
        push_pkt(1, 6, 8'h60, 1'b0);
        exp_bytes(8'h60, 4);
        exp_bytes(8'h70, 1);
        exp_bytes(8'h64, 2);
        cycle();
        cycle();
        push_pkt(2, 1, 8'h70, 1'b1);
        en = 4'b0110;
        wait_wr("t4_bytes", base + 7, 40);
        chk("t4_trunc_once", 32'(n_trunc - t0), 32'd1);
        chk("t4_gseq_len", 32'(gseq.size()), 32'd3);
        e_seq = '{1, 2, 1, 0, 0};
        for (int i = 0; i < 3 && i < gseq.size(); i++) chk("t4_gseq", 32'(gseq[i]), 32'(e_seq[i]));
        chk("t4_grant_held", 32'(grant), 32'b0010);

        // Reset with 2 bytes of requester 1's packet written; pointer restarts at 0.
        reset_drv = 1'b1;
        cycle();
        reset_drv = 1'b0;
        cycle();
        chk("t5_grant", 32'(grant), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_ready", 32'(bus.req_ready), 32'h0);
        gseq.delete();
        t0 = n_trunc;
        push_pkt(0, 4, 8'h80, 1'b0);
        push_pkt(3, 1, 8'h90, 1'b1);
        exp_bytes(8'h80, 4);
        exp_bytes(8'h90, 1);
        en = 4'b1001;
        wait_idle("t5_idle", 40);
        chk("t5_gseq_len", 32'(gseq.size()), 32'd2);
        chk("t5_first_req0", 32'(gseq[0]), 32'd0);
        chk("t5_then_req3", 32'(gseq[1]), 32'd3);
        chk("t5_trunc_at_4", 32'(n_trunc - t0), 32'd1);

        // Owner goes quiet after one byte.
        en = 4'b0100;
        push_pkt(2, 1, 8'hA0, 1'b0);
        exp_bytes(8'hA0, 1);
        wait_wr("t6_byte", n_wr + 1, 20);
`ifdef AS_FIFO_WR_ARB_TIMEOUT_EN
        repeat (10) cycle();
        chk("t6_held_idle10", 32'(grant), 32'b0100);
        cycle();
        chk("t6_revoked", 32'(grant), 32'h0);
        chk("t6_trunc_pulse", 32'(pkt_trunc), 32'h1);
`else
        repeat (120) cycle();
        chk("t6_held_grant", 32'(grant), 32'b0100);
        chk("t6_held_busy", 32'(busy), 32'h1);
        chk("t6_no_trunc", 32'(pkt_trunc), 32'h0);
`endif
        reset_drv = 1'b1;
        cycle();
        reset_drv = 1'b0;
        cycle();
        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/as_fifo_wr_arbiter.md
Name: as_fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the write side of the bridge's 512x8 byte FIFO among NUM_REQ byte-stream requesters (serial RX, monitor/status sources, etc.).
- Grants are packet-locked: the owner keeps the FIFO until it flags its last byte, so bytes from different requesters never interleave.
- Sits in the FIFO write-clock domain, directly in front of the FIFO write port. Back-pressure comes from the FIFO almost-full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_PKT, 256, maximum bytes per grant before forced release (2..4096).
- TIMEOUT, 255, idle cycles allowed mid-packet before grant is revoked (used only with the optional feature).

Ports:
- clk  input  1  write-side clock, shared with the FIFO write clock.
- reset  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  NUM_REQ  marks the final byte of a packet.
- req_ready  output  NUM_REQ  byte accepted when req_valid[i] && req_ready[i].
- grant  output  NUM_REQ  registered one-hot current owner; all zero when idle.
- fifo_wr_data  output  8  byte to FIFO.
- fifo_wr_en  output  1  FIFO write strobe, active-high.
- fifo_afull  input  1  FIFO almost-full (level 510).
- busy  output  1  high while in state OWN.
- pkt_trunc  output  1  one-cycle pulse when a grant is force-released by MAX_PKT or timeout.

Behaviour:
- State machine: IDLE, OWN.
- Reset values: state IDLE, grant 0, busy 0, pkt_trunc 0, byte counter 0, last-owner pointer NUM_REQ-1 (so requester 0 wins first).
- IDLE:
  - If any req_valid is high, pick the first valid requester strictly after the last owner, wrapping round.
  - Register its grant bit and move to OWN.
  - One cycle of arbitration latency: nothing is written in the cycle the grant is decided.
- OWN, owner g:
  - req_ready[g] = !fifo_afull. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] && req_ready[g], combinational. fifo_wr_data = owner's byte.
  - Every transfer increments the 12-bit byte counter.
- Release to IDLE:
  - On a transfer with req_last[g] high.
  - Or on the transfer that makes the counter equal MAX_PKT without req_last; this also pulses pkt_trunc.
  - On release: grant cleared, counter cleared, last-owner pointer set to g.
- Simultaneous last byte and MAX_PKT: treated as a normal end, no pkt_trunc.
- fifo_afull high: the transfer stalls and the grant is held. The two-entry margin absorbs FIFO flag latency, so writes never reach a truly full FIFO.
- A requester that deasserts valid mid-packet keeps the grant (without the optional feature).
- Reset mid-packet: immediate return to reset values. A partial packet already in the FIFO is not retracted.
- No starvation: each requester waits at most NUM_REQ-1 packets of at most MAX_PKT bytes each.

Optional Feature:
- Macro AS_FIFO_WR_ARB_TIMEOUT_EN.
- Defined: an 8-bit idle counter runs in OWN.
  - Clears on each transfer and while fifo_afull is high.
  - Increments while the owner's req_valid is low.
  - On reaching TIMEOUT, the grant is released as a truncation: pkt_trunc pulses, last-owner pointer is set to g.
- Undefined: no idle counter; the grant is held indefinitely until req_last or MAX_PKT.

Decomposition:
- Package as_arb_pkg holds:
  - the state enum (IDLE, OWN);
  - the byte-counter width constant (12);
  - the idle-counter width constant (8);
  - the requester index width, derived from NUM_REQ by clog2.
- One sub-module, as_rr_pick: combinational round-robin picker.
  - Inputs: request vector and last-owner index.
  - Outputs: one-hot pick and valid.
  - Reusable for the read-side scheduler.

Test Plan:
- Reset, then req_valid=4'b0101: grant=0001 one cycle after request; requester 0 sends 3 bytes ending with req_last; next grant=0100; FIFO receives 3 bytes of req 0 then req 2 bytes in order.
- All four requesters hold continuous 2-byte packets: grant sequence 0,1,2,3,0. No byte interleaving inside a packet. busy drops for exactly one cycle between packets.
- Owner streams with fifo_afull forced high for 5 cycles mid-packet: fifo_wr_en=0 and req_ready=0 for those 5 cycles; grant unchanged; data resumes without loss or duplication.
- MAX_PKT=4, requester 1 sends 6 bytes without last: after byte 4, pkt_trunc pulses once and grant moves to the next valid requester; byte 5 waits for a new grant.
- Reset asserted mid-packet after 2 bytes: next cycle grant=0, busy=0, req_ready=0, counter 0; the following arbitration starts at requester 0.
- With AS_FIFO_WR_ARB_TIMEOUT_EN and TIMEOUT=10, owner drops valid after 1 byte: grant revoked on idle cycle 10 with pkt_trunc; without the macro, grant held for 100+ cycles.
